i2s_tx: RTL and testbench

I2S transmitter, the output counterpart of the mic `i2s` receiver. It serialises 16-bit signed stereo samples onto a three-wire I2S bus (BCLK, LRCLK, SDATA) for an external DAC/class-D amp on a PMOD header. It generates its own bit and word clocks from `audio_clk` (98.304 MHz): BCLK = 3.072 MHz, 64 BCLK per frame, 48 kHz frame rate. Upstream writes samples through a one-deep valid/ready holding register; the block latches each sample once per frame.

---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_clk_gen.sv | 48 ++++
 rtl/i2s_tx.sv | 108 ++++++++++
 tb/tb_i2s_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmit and receive paths.
package audio_pkg;

  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } stereo_sample_t;

  localparam int AUDIO_CLK_HZ      = 98_304_000;
  localparam int I2S_BCLK_DIV_LOG2 = 5;
  localparam int I2S_FRAME_BCLKS   = 64;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit/word clock generator: divider and bit counters, registered BCLK/LRCLK,
// and the frame-latch strobe on the last audio_clk cycle of a frame.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int DIV_LOG2       = I2S_BCLK_DIV_LOG2,
  parameter int SLOT_BITS_LOG2 = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      bclk_o,
  output logic                      lrclk_o,
  output logic [SLOT_BITS_LOG2:0]   bit_cnt_o,
  output logic                      fl_o
);

  logic [DIV_LOG2-1:0]     div_q, div_d;
  logic [SLOT_BITS_LOG2:0] bit_q, bit_d;
  logic                    bclk_q, lrclk_q;
  logic                    div_wrap;

  always_comb begin
    div_wrap = &div_q;
    div_d    = div_q + DIV_LOG2'(1);
    bit_d    = div_wrap ? bit_q + (SLOT_BITS_LOG2 + 1)'(1) : bit_q;
    fl_o     = div_wrap && (&bit_q);
  end

  // Clock outputs lag the counters by one cycle so they line up with registered sdata.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= div_q[DIV_LOG2-1];
      lrclk_q <= bit_q[SLOT_BITS_LOG2];
    end
  end

  assign bclk_o    = bclk_q;
  assign lrclk_o   = lrclk_q;
  assign bit_cnt_o = bit_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S stereo transmitter with a one-deep valid/ready holding register.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int BCLK_DIV_LOG2  = I2S_BCLK_DIV_LOG2,
  parameter int SLOT_BITS_LOG2 = 5
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  output logic                    bclk_out,
  output logic                    lrclk_out,
  output logic                    sdata_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  logic [SLOT_BITS_LOG2:0]   bit_cnt;
  logic                      fl;

  logic [SAMPLE_WIDTH-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0]   frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic                      hold_full_q, hold_full_d;
  logic                      sdata_q, sdata_d;
  logic                      underrun;
  logic [SLOT_BITS_LOG2-1:0] slot_pos;
  logic [SAMPLE_WIDTH-1:0]   frame_sel, frame_shift;

  i2s_clk_gen #(
    .DIV_LOG2       (BCLK_DIV_LOG2),
    .SLOT_BITS_LOG2 (SLOT_BITS_LOG2)
  ) u_clk_gen (
    .clk_i     (audio_clk),
    .rst_ni    (rst_in),
    .bclk_o    (bclk_out),
    .lrclk_o   (lrclk_out),
    .bit_cnt_o (bit_cnt),
    .fl_o      (fl)
  );

  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun    = 1'b0;

    if (fl) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else if (sample_valid_in) begin
        // Late producer: hand the offered pair straight to the frame registers.
        frame_l_d = left_in;
        frame_r_d = right_in;
      end else begin
        frame_l_d = '0;
        frame_r_d = '0;
        underrun  = 1'b1;
      end
    end else if (sample_valid_in && !hold_full_q) begin
      hold_l_d    = left_in;
      hold_r_d    = right_in;
      hold_full_d = 1'b1;
    end

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    slot_pos = bit_cnt[SLOT_BITS_LOG2-1:0];
`else
    slot_pos = bit_cnt[SLOT_BITS_LOG2-1:0] - SLOT_BITS_LOG2'(1);
`endif
    // Shifting out past the sample width leaves zeros, which pads the slot tail.
    frame_sel   = bit_cnt[SLOT_BITS_LOG2] ? frame_r_q : frame_l_q;
    frame_shift = frame_sel << slot_pos;
    sdata_d     = frame_shift[SAMPLE_WIDTH-1];
  end

  always_ff @(posedge audio_clk) begin
    if (!rst_in) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      sdata_q     <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      sdata_q     <= sdata_d;
    end
  end

  assign sample_ready_out = ~hold_full_q;
  assign sdata_out        = sdata_q;
  assign frame_start_out  = fl;
  assign underrun_out     = underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: cycle model for clocks/strobes/ready and a
// frame scoreboard fed by the model, drained by a BCLK-rising-edge serial monitor.
module tb_i2s_tx;

  localparam int FRAME_CYC = 2048;
  localparam int FL_CNT    = FRAME_CYC - 1;

  logic        audio_clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        sample_valid_in = 1'b0;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        sample_ready_out, bclk_out, lrclk_out, sdata_out;
  logic        frame_start_out, underrun_out;

  always #5 audio_clk = ~audio_clk;

  i2s_tx dut (
    .audio_clk        (audio_clk),
    .rst_in           (rst_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .left_in          (left_in),
    .right_in         (right_in),
    .bclk_out         (bclk_out),
    .lrclk_out        (lrclk_out),
    .sdata_out        (sdata_out),
    .frame_start_out  (frame_start_out),
    .underrun_out     (underrun_out)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial image of one frame, MSB = first BCLK of the left slot.
  function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return {l, 16'h0000, r, 16'h0000};
`else
    return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
`endif
  endfunction

  // Reference model: m_cnt is the combined bit/div count of the current cycle.
  int          m_cnt = 0;
  bit          m_full = 1'b0;
  bit          m_live = 1'b0;
  bit          m_bclk = 1'b0;
  bit          m_lr = 1'b0;
  logic [15:0] m_hold_l = '0;
  logic [15:0] m_hold_r = '0;

  always @(posedge audio_clk) begin
    if (!rst_in) begin
      m_cnt  = 0;
      m_full = 1'b0;
      m_bclk = 1'b0;
      m_lr   = 1'b0;
      m_live = 1'b1;
      exp_q.delete();
      exp_q.push_back(64'h0);
    end else begin
      m_bclk = m_cnt[4];
      m_lr   = m_cnt[10];
      if (m_cnt == FL_CNT) begin
        if (m_full) begin
          exp_q.push_back(mk_frame(m_hold_l, m_hold_r));
          m_full = 1'b0;
        end else if (sample_valid_in) begin
          exp_q.push_back(mk_frame(left_in, right_in));
        end else begin
          exp_q.push_back(64'h0);
        end
      end else if (sample_valid_in && !m_full) begin
        m_hold_l = left_in;
        m_hold_r = right_in;
        m_full   = 1'b1;
      end
      m_cnt = (m_cnt + 1) % FRAME_CYC;
    end
  end

  // Per-cycle checks of clocks, strobes and ready.
  int n_ur = 0;
  always @(negedge audio_clk) begin
    if (m_live) begin
      check("bclk", bclk_out, m_bclk);
      check("lrclk", lrclk_out, m_lr);
      check("frame_start", frame_start_out, m_cnt == FL_CNT);
      check("underrun", underrun_out, (m_cnt == FL_CNT) && !m_full && !sample_valid_in);
      check("ready", sample_ready_out, !m_full);
      if (underrun_out) n_ur++;
    end
  end

  // Serial monitor: capture sdata on BCLK rising edges, compare whole frames.
  int          bpos = 0;
  int          frames_seen = 0;
  bit          prev_bclk = 1'b0;
  logic [63:0] cap = '0;
  always @(negedge audio_clk) begin
    if (!rst_in) begin
      bpos      = 0;
      prev_bclk = 1'b0;
    end else if (m_live) begin
      if (bclk_out && !prev_bclk) begin
        cap[63-bpos] = sdata_out;
        if (bpos == 63) begin
          if (exp_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
          else check("frame", cap, exp_q.pop_front());
          frames_seen++;
          bpos = 0;
        end else begin
          bpos++;
        end
      end
      prev_bclk = bclk_out;
    end
  end

  task automatic step();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    bit rdy;
    left_in = l;
    right_in = r;
    sample_valid_in = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge audio_clk);
      rdy = sample_ready_out;
      step();
      if (rdy) begin
        sample_valid_in = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd0, 64'd1);
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    for (int i = 0; i < 5000; i++) begin
      if (m_cnt == target) return;
      step();
    end
    check("wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ur_base;
    int fr_base;
    rst_in = 1'b0;
    repeat (4) step();
    @(negedge audio_clk);
    check("rst_bclk", bclk_out, 0);
    check("rst_lrclk", lrclk_out, 0);
    check("rst_sdata", sdata_out, 0);
    check("rst_fs", frame_start_out, 0);
    check("rst_ur", underrun_out, 0);
    check("rst_ready", sample_ready_out, 1);
    step();
    rst_in = 1'b1;

    // First frame latch with nothing offered.
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge audio_clk);
      if (frame_start_out) break;
      n++;
    end
    check("first_fl_cycle", n, FL_CNT);
    check("first_fl_underrun", underrun_out, 1);
    step();

    // Known pattern, then a continuous stream of incrementing pairs.
    send(16'hA5C3, 16'h8001);
    ur_base = n_ur;
    for (int i = 0; i < 11; i++) send(16'h0100 + 16'(i), 16'hF000 - 16'(i));
    wait_cnt(FL_CNT);
    @(negedge audio_clk);
    check("stream_last_fl_ur", underrun_out, 0);
    check("stream_underruns", n_ur - ur_base, 0);
    step();

    // Bypass: offer only in the frame-latch cycle with the holding register empty.
    wait_cnt(FL_CNT);
    left_in = 16'h7FFF;
    right_in = 16'h1234;
    sample_valid_in = 1'b1;
    @(negedge audio_clk);
    check("bypass_fs", frame_start_out, 1);
    check("bypass_ur", underrun_out, 0);
    check("bypass_ready", sample_ready_out, 1);
    step();
    sample_valid_in = 1'b0;
    @(negedge audio_clk);
    check("bypass_ready_after", sample_ready_out, 1);
    step();
    wait_cnt(FL_CNT);
    step();

    // Mid-frame reset with a pair parked in holding; offers during reset are dropped.
    send(16'hDEAD, 16'hBEEF);
    wait_cnt(20 * 32);
    rst_in = 1'b0;
    left_in = 16'h1111;
    right_in = 16'h2222;
    sample_valid_in = 1'b1;
    step();
    @(negedge audio_clk);
    check("mid_rst_bclk", bclk_out, 0);
    check("mid_rst_lrclk", lrclk_out, 0);
    check("mid_rst_sdata", sdata_out, 0);
    check("mid_rst_fs", frame_start_out, 0);
    check("mid_rst_ur", underrun_out, 0);
    check("mid_rst_ready", sample_ready_out, 1);
    step();
    step();
    sample_valid_in = 1'b0;
    rst_in = 1'b1;
    fr_base = frames_seen;
    repeat (2 * FRAME_CYC + 100) step();
    check("post_rst_frames", frames_seen - fr_base, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
